program_counter: RTL and testbench

//   Fetch-address generator for the processor front end, one stage upstream/downstream of the stall delay counter.
//   - Consumes the counter's pcEn as pc_en, which gates sequential advance.
//   - Produces delay_en, which drives the counter's delayEn input and starts a pipeline stall on every taken branch/jump.
//   - Holds the fetch PC, applies redirects and supports a sticky halt.

---
 rtl/program_counter.sv | 91 +++++++++
 tb/tb_program_counter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Fetch-address generator: holds the fetch PC, applies taken-branch redirects,
// pulses delay_en to the stall delay counter, and supports a sticky halt.
module program_counter #(
    parameter int ADDR_W     = 8,
    parameter int RESET_ADDR = 0,
    parameter int INC        = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_en,
    input  logic              branch_valid,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_valid,
    output logic              delay_en,
    output logic              halted
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        REDIRECT,
        HALTED
    } pcState_t;

    localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_ADDR);
    localparam logic [ADDR_W-1:0] INC_STEP = ADDR_W'(INC);

    pcState_t state;
    logic     takeBranch;

    assign takeBranch = branch_valid & branch_taken;

    // Redirect outranks pc_en so a branch resolved during a stall is never lost;
    // REDIRECT ignores branch_valid so delay_en always gets a low cycle between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
            delay_en    <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                end
                RUN: begin
                    if (halt) begin
                        state       <= HALTED;
                        fetch_valid <= 1'b0;
                        halted      <= 1'b1;
                    end else if (takeBranch) begin
                        state       <= REDIRECT;
                        pc          <= branch_target;
                        delay_en    <= 1'b1;
                        fetch_valid <= 1'b0;
                    end else if (pc_en) begin
                        pc <= pc + INC_STEP;
                    end
                end
                REDIRECT: begin
                    delay_en <= 1'b0;
                    if (halt) begin
                        state       <= HALTED;
                        fetch_valid <= 1'b0;
                        halted      <= 1'b1;
                    end else begin
                        state       <= RUN;
                        fetch_valid <= 1'b1;
                    end
                end
                HALTED: begin
                    fetch_valid <= 1'b0;
                    delay_en    <= 1'b0;
                    halted      <= 1'b1;
                end
                default: begin
                    state       <= BOOT;
                    fetch_valid <= 1'b0;
                    delay_en    <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_counter.sv
// Table-driven directed bench for program_counter, plus hand-written
// sequences for halt absorption, BOOT input masking and async reset aborts.
module tb_program_counter;

    logic       clk;
    logic       rst_n;
    logic       pc_en;
    logic       branch_valid;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic       halt;
    logic [7:0] pc;
    logic       fetch_valid;
    logic       delay_en;
    logic       halted;

    int compared;
    int mismatched;

    typedef struct {
        logic       pcEn;
        logic       bValid;
        logic       bTaken;
        logic [7:0] target;
        logic       halt;
        logic [7:0] expPc;
        logic       expFv;
        logic       expDe;
        logic       expHalted;
    } vector_t;

    vector_t vecs[27];

    program_counter #(
        .ADDR_W    (8),
        .RESET_ADDR(0),
        .INC       (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_en        (pc_en),
        .branch_valid (branch_valid),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt         (halt),
        .pc           (pc),
        .fetch_valid  (fetch_valid),
        .delay_en     (delay_en),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vector_t mk(input logic pe, input logic bv, input logic bt,
                                   input logic [7:0] tg, input logic hl,
                                   input logic [7:0] ePc, input logic eFv,
                                   input logic eDe, input logic eH);
        vector_t v;
        v.pcEn = pe;  v.bValid = bv; v.bTaken = bt; v.target = tg; v.halt = hl;
        v.expPc = ePc; v.expFv = eFv; v.expDe = eDe; v.expHalted = eH;
        return v;
    endfunction

    task automatic applyStimulus(input logic pe, input logic bv, input logic bt,
                                 input logic [7:0] tg, input logic hl);
        pc_en         = pe;
        branch_valid  = bv;
        branch_taken  = bt;
        branch_target = tg;
        halt          = hl;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] ePc,
                               input logic eFv, input logic eDe, input logic eH);
        compared++;
        if (pc !== ePc || fetch_valid !== eFv || delay_en !== eDe || halted !== eH) begin
            mismatched++;
            $display("[TB] FAIL %s: got pc=%02h fv=%b de=%b halted=%b, expected pc=%02h fv=%b de=%b halted=%b",
                     name, pc, fetch_valid, delay_en, halted, ePc, eFv, eDe, eH);
        end
    endtask

    task automatic stepAndCheck(input string name, input logic [7:0] ePc,
                                input logic eFv, input logic eDe, input logic eH);
        @(posedge clk);
        #1;
        checkOutput(name, ePc, eFv, eDe, eH);
    endtask

    task automatic resetAndRelease();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        // Increment from reset, stalled redirect, not-taken branches,
        // redirect during REDIRECT, wrap from all-ones, then halt at pc=9.
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h40, 1'b0, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h41, 1'b1, 1'b0, 1'b0);
        vecs[10] = mk(1'b1, 1'b1, 1'b1, 8'h06, 1'b0, 8'h06, 1'b0, 1'b1, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h06, 1'b1, 1'b0, 1'b0);
        vecs[12] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h07, 1'b1, 1'b0, 1'b0);
        vecs[13] = mk(1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0);
        vecs[14] = mk(1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0);
        vecs[15] = mk(1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0);
        vecs[17] = mk(1'b0, 1'b1, 1'b1, 8'h30, 1'b0, 8'h30, 1'b0, 1'b1, 1'b0);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h30, 1'b1, 1'b0, 1'b0);
        vecs[19] = mk(1'b1, 1'b1, 1'b1, 8'hFE, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0);
        vecs[20] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
        vecs[21] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        vecs[22] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        vecs[23] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
        vecs[24] = mk(1'b0, 1'b1, 1'b1, 8'h09, 1'b0, 8'h09, 1'b0, 1'b1, 1'b0);
        vecs[25] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h09, 1'b1, 1'b0, 1'b0);
        vecs[26] = mk(1'b1, 1'b1, 1'b1, 8'hAA, 1'b1, 8'h09, 1'b0, 1'b0, 1'b1);

        resetAndRelease();
        for (int i = 0; i < 27; i++) begin
            applyStimulus(vecs[i].pcEn, vecs[i].bValid, vecs[i].bTaken,
                          vecs[i].target, vecs[i].halt);
            stepAndCheck($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expFv,
                         vecs[i].expDe, vecs[i].expHalted);
        end

        // HALTED absorbs every input combination.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                          8'($urandom_range(255)), 1'($urandom_range(1)));
            stepAndCheck($sformatf("halted_hold%0d", i), 8'h09, 1'b0, 1'b0, 1'b1);
        end

        // Async reset while halted takes effect before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_halted", 8'h00, 1'b0, 1'b0, 1'b0);

        // BOOT ignores halt/branch; halt during REDIRECT still halts.
        resetAndRelease();
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
        stepAndCheck("boot_ignores_inputs", 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h22, 1'b0);
        stepAndCheck("redirect_to_22", 8'h22, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        stepAndCheck("halt_in_redirect", 8'h22, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        stepAndCheck("halt_sticky", 8'h22, 1'b0, 1'b0, 1'b1);

        // Async reset in the middle of a redirect pulse aborts it.
        resetAndRelease();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        stepAndCheck("boot_again", 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h50, 1'b0);
        stepAndCheck("redirect_to_50", 8'h50, 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_redirect", 8'h00, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
